// File: rtl/ymux_rr_stream.sv
// Registered CHANNELS-way valid/ready stream mux; round-robin, or fixed priority with YMUX_FIXED_PRIO_EN.
// Latency: one cycle from input transfer to out_valid; one word per cycle sustained.
// Backpressure: out_ready low with out_valid high holds the output word and drops every in_ready.
module ymux_rr_stream #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int CNTW     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SELW-1:0]           force_sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_ch,
  input  logic                      out_ready,
  output logic [CNTW-1:0]           xfer_cnt
);

  logic                load;
  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] rot;
  logic [SELW-1:0]     off;
  logic                gnt_vld;
  logic [SELW-1:0]     gnt;
  logic [SELW-1:0]     gnt_nxt;
  logic [WIDTH-1:0]    sel_dat;
  logic                xfer;

  assign load = !out_valid || out_ready;

  // An out-of-range force_sel matches no channel, leaving nothing eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      elig[i] = in_valid[i] && (!force_en || (force_sel == SELW'(i)));
    end
  end

`ifdef YMUX_FIXED_PRIO_EN
  assign rot = elig;

  always_comb begin
    gnt = off;
  end
`else
  logic [SELW-1:0]       ptr;
  logic [2*CHANNELS-1:0] dbl;
  logic [SELW:0]         gsum;

  // Rotate so that bit 0 of rot is channel ptr; the first set bit is the winner's offset.
  assign dbl = {elig, elig} >> ptr;
  assign rot = dbl[CHANNELS-1:0];

  always_comb begin
    gsum = {1'b0, ptr} + {1'b0, off};
    if (gsum >= (SELW+1)'(CHANNELS)) begin
      gsum = gsum - (SELW+1)'(CHANNELS);
    end
    gnt = gsum[SELW-1:0];
  end
`endif

  always_comb begin
    gnt_vld = 1'b0;
    off     = '0;
    for (int k = CHANNELS-1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        off     = SELW'(k);
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt == SELW'(i)) begin
        sel_dat = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (gnt_vld && load) begin
      in_ready[gnt] = 1'b1;
    end
  end

  assign xfer    = gnt_vld && load;
  assign gnt_nxt = (gnt == SELW'(CHANNELS-1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_dat;
        out_ch    <= gnt;
        xfer_cnt  <= xfer_cnt + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifndef YMUX_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= gnt_nxt;
    end
  end
`else
  logic unused_gnt_nxt;
  assign unused_gnt_nxt = ^gnt_nxt;
`endif

endmodule
